// File: rtl/fpu_result_collect.sv
// Result-side collector: assembles single/double FPU result words into a
// one-entry buffer, classifies the value and offers it to write-back.
module fpu_result_collect (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fpout,
    input  logic        res_valid,
    input  logic        res_double,
    output logic        res_ready,
    input  logic        fpuhold,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_double,
    output logic [1:0]  wb_class
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbl_q, dbl_d;
    logic [1:0]  cls_q, cls_d;

    logic        accept;
    logic        drain;
    logic [1:0]  cls_single;
    logic [1:0]  cls_double;

    // Sign is ignored; denormals count as finite nonzero.
    function automatic logic [1:0] classify(
        input logic exp_ones,
        input logic exp_zero,
        input logic man_zero
    );
        if (exp_ones) return man_zero ? 2'd2 : 2'd3;
        if (exp_zero && man_zero) return 2'd1;
        return 2'd0;
    endfunction

    assign res_ready = (state_q != FULL) | wb_ready;
    assign wb_valid  = (state_q == FULL) & ~fpuhold;
    assign accept    = res_valid & res_ready & ~fpuhold & ~flush;
    assign drain     = wb_valid & wb_ready;

    assign cls_single = classify(&fpout[30:23], ~|fpout[30:23],
                                 ~|fpout[22:0]);
    assign cls_double = classify(&hi_q[30:20], ~|hi_q[30:20],
                                 ~|{hi_q[19:0], fpout});

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbl_d   = dbl_q;
        cls_d   = cls_q;
        if (flush) begin
            state_d = IDLE;
            hi_d    = 32'd0;
            lo_d    = 32'd0;
            dbl_d   = 1'b0;
            cls_d   = 2'd0;
        end else if (!fpuhold) begin
            case (state_q)
                IDLE, FULL: begin
                    // In FULL, accept implies a same-cycle drain (refill).
                    if (accept) begin
                        hi_d  = fpout;
                        dbl_d = res_double;
                        if (res_double) begin
                            state_d = HI;
                        end else begin
                            lo_d    = 32'd0;
                            cls_d   = cls_single;
                            state_d = FULL;
                        end
                    end else if (state_q == FULL && drain) begin
                        state_d = IDLE;
                    end
                end
                HI: begin
                    if (accept) begin
                        lo_d    = fpout;
                        cls_d   = cls_double;
                        state_d = FULL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dbl_q   <= 1'b0;
            cls_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbl_q   <= dbl_d;
            cls_q   <= cls_d;
        end
    end

    assign wb_hi     = hi_q;
    assign wb_lo     = lo_q;
    assign wb_double = dbl_q;
    assign wb_class  = cls_q;

endmodule

// File: tb/tb_fpu_result_collect.sv
// Self-checking bench for fpu_result_collect: vector table plus
// hand-written stall/flush/backpressure/reset sequences, scoreboard-checked.
module tb_fpu_result_collect;

    logic        clk;
    logic        reset;
    logic [31:0] fpout;
    logic        res_valid;
    logic        res_double;
    logic        res_ready;
    logic        fpuhold;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_double;
    logic [1:0]  wb_class;

    typedef struct {
        logic        dbl;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  cls;
    } vec_t;

    vec_t tbl[16];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fpu_result_collect dut (
        .clk       (clk),
        .reset     (reset),
        .fpout     (fpout),
        .res_valid (res_valid),
        .res_double(res_double),
        .res_ready (res_ready),
        .fpuhold   (fpuhold),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_hi     (wb_hi),
        .wb_lo     (wb_lo),
        .wb_double (wb_double),
        .wb_class  (wb_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic dbl, input logic [31:0] hi,
                        input logic [31:0] lo, input logic [1:0] cls);
        vec_t v;
        v.dbl = dbl;
        v.hi  = hi;
        v.lo  = lo;
        v.cls = cls;
        sb.push_back(v);
    endtask

    // Drive one word and wait (bounded) for the cycle in which it is taken.
    task automatic send_word(input logic [31:0] w, input logic dbl);
        int n;
        n = 0;
        @(negedge clk);
        fpout      = w;
        res_double = dbl;
        res_valid  = 1'b1;
        #1;
        while (!(res_ready && !fpuhold && !flush) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_word timeout word=%h", w);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        res_valid = 1'b0;
        #1;
    endtask

    // Scoreboard: every write-back transfer must match the oldest expectation.
    always @(negedge clk) begin
        #2;
        if (!reset && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%h required=none", wb_hi);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("sb_hi", wb_hi, e.hi);
                chk("sb_lo", wb_lo, e.lo);
                chk("sb_dbl", {31'd0, wb_double}, {31'd0, e.dbl});
                chk("sb_cls", {30'd0, wb_class}, {30'd0, e.cls});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 32'h3F800000, 32'h0, 2'd0};
        tbl[1]  = '{1'b0, 32'h00000000, 32'h0, 2'd1};
        tbl[2]  = '{1'b0, 32'h80000000, 32'h0, 2'd1};
        tbl[3]  = '{1'b0, 32'h7F800000, 32'h0, 2'd2};
        tbl[4]  = '{1'b0, 32'hFF800001, 32'h0, 2'd3};
        tbl[5]  = '{1'b0, 32'h00000001, 32'h0, 2'd0};
        tbl[6]  = '{1'b0, 32'h7F7FFFFF, 32'h0, 2'd0};
        tbl[7]  = '{1'b1, 32'h7FF00000, 32'h00000000, 2'd2};
        tbl[8]  = '{1'b1, 32'h7FF00000, 32'h00000001, 2'd3};
        tbl[9]  = '{1'b1, 32'h00000000, 32'h00000000, 2'd1};
        tbl[10] = '{1'b1, 32'h00000000, 32'h00000001, 2'd0};
        tbl[11] = '{1'b1, 32'h80000000, 32'h00000000, 2'd1};
        tbl[12] = '{1'b1, 32'h400921FB, 32'h54442D18, 2'd0};
        tbl[13] = '{1'b1, 32'hFFF80000, 32'h00000000, 2'd3};
        tbl[14] = '{1'b1, 32'h00100000, 32'h00000000, 2'd0};
        tbl[15] = '{1'b0, 32'h7FC00000, 32'h0, 2'd3};

        reset      = 1'b1;
        fpout      = 32'd0;
        res_valid  = 1'b0;
        res_double = 1'b0;
        fpuhold    = 1'b0;
        flush      = 1'b0;
        wb_ready   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_ready", {31'd0, res_ready}, 32'd1);
        chk("rst_hi", wb_hi, 32'd0);
        chk("rst_lo", wb_lo, 32'd0);
        chk("rst_dbl", {31'd0, wb_double}, 32'd0);
        chk("rst_cls", {30'd0, wb_class}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        wb_ready = 1'b1;

        // Single, one-cycle latency, then back to empty.
        send_word(32'h3F800000, 1'b0);
        push(1'b0, 32'h3F800000, 32'h0, 2'd0);
        idle_cycle();
        chk("single_valid", {31'd0, wb_valid}, 32'd1);
        chk("single_hi", wb_hi, 32'h3F800000);
        chk("single_lo", wb_lo, 32'd0);
        idle_cycle();
        chk("single_idle", {31'd0, wb_valid}, 32'd0);

        // Double: not valid while in HI, valid one cycle after low word.
        send_word(32'h7FF00000, 1'b1);
        send_word(32'h00000000, 1'b0);
        chk("dbl_hi_notvalid", {31'd0, wb_valid}, 32'd0);
        push(1'b1, 32'h7FF00000, 32'h0, 2'd2);
        idle_cycle();
        chk("dbl_valid", {31'd0, wb_valid}, 32'd1);
        chk("dbl_cls_inf", {30'd0, wb_class}, 32'd2);
        send_word(32'h7FF00000, 1'b1);
        send_word(32'h00000001, 1'b0);
        push(1'b1, 32'h7FF00000, 32'h1, 2'd3);
        idle_cycle();
        chk("dbl_cls_nan", {30'd0, wb_class}, 32'd3);
        chk("dbl_flag", {31'd0, wb_double}, 32'd1);

        // Back-to-back table traffic at full throughput.
        foreach (tbl[i]) begin
            send_word(tbl[i].hi, tbl[i].dbl);
            if (tbl[i].dbl) send_word(tbl[i].lo, 1'b0);
            push(tbl[i].dbl, tbl[i].hi, tbl[i].lo, tbl[i].cls);
        end
        idle_cycle();
        idle_cycle();

        // Backpressure then same-cycle drain and refill.
        wb_ready = 1'b0;
        send_word(32'h80000000, 1'b0);
        push(1'b0, 32'h80000000, 32'h0, 2'd1);
        @(negedge clk);
        fpout      = 32'h40490FDB;
        res_double = 1'b0;
        res_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", {31'd0, res_ready}, 32'd0);
            chk("bp_valid", {31'd0, wb_valid}, 32'd1);
            chk("bp_hi", wb_hi, 32'h80000000);
            chk("bp_cls", {30'd0, wb_class}, 32'd1);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1;
        chk("refill_ready", {31'd0, res_ready}, 32'd1);
        push(1'b0, 32'h40490FDB, 32'h0, 2'd0);
        idle_cycle();
        chk("refill_valid", {31'd0, wb_valid}, 32'd1);
        chk("refill_hi", wb_hi, 32'h40490FDB);
        chk("refill_cls", {30'd0, wb_class}, 32'd0);
        idle_cycle();

        // Stall between the words of a double.
        send_word(32'h7FF00000, 1'b1);
        @(negedge clk);
        fpout      = 32'h00000000;
        res_double = 1'b0;
        res_valid  = 1'b1;
        fpuhold    = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("hold_valid", {31'd0, wb_valid}, 32'd0);
            @(negedge clk);
        end
        fpuhold = 1'b0;
        #1;
        push(1'b1, 32'h7FF00000, 32'h0, 2'd2);
        idle_cycle();
        chk("hold_after_valid", {31'd0, wb_valid}, 32'd1);
        chk("hold_after_dbl", {31'd0, wb_double}, 32'd1);
        idle_cycle();

        // Flush while in HI; the word in the flush cycle is dropped.
        send_word(32'h400921FB, 1'b1);
        @(negedge clk);
        fpout     = 32'h54442D18;
        res_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        res_valid = 1'b0;
        #1;
        chk("flush_hi_valid", {31'd0, wb_valid}, 32'd0);
        chk("flush_hi_hi", wb_hi, 32'd0);
        chk("flush_hi_dbl", {31'd0, wb_double}, 32'd0);
        send_word(32'h00000000, 1'b0);
        push(1'b0, 32'h0, 32'h0, 2'd1);
        idle_cycle();
        chk("flush_next_cls", {30'd0, wb_class}, 32'd1);
        chk("flush_next_dbl", {31'd0, wb_double}, 32'd0);
        idle_cycle();

        // Flush while FULL under stall.
        wb_ready = 1'b0;
        send_word(32'h3F800000, 1'b0);
        @(negedge clk);
        res_valid = 1'b0;
        fpuhold   = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_full_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        fpuhold  = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b1;
        #1;
        chk("flush_full_after", {31'd0, wb_valid}, 32'd0);
        chk("flush_full_hi", wb_hi, 32'd0);
        send_word(32'h00000000, 1'b0);
        push(1'b0, 32'h0, 32'h0, 2'd1);
        idle_cycle();
        chk("flush_full_next", {30'd0, wb_class}, 32'd1);
        idle_cycle();

        // Asynchronous reset between high and low words.
        send_word(32'h7FF00000, 1'b1);
        @(negedge clk);
        res_valid = 1'b0;
        #1;
        chk("prerst_hi", wb_hi, 32'h7FF00000);
        reset = 1'b1;
        #1;
        chk("arst_hi", wb_hi, 32'd0);
        chk("arst_dbl", {31'd0, wb_double}, 32'd0);
        chk("arst_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send_word(32'h7F800000, 1'b0);
        push(1'b0, 32'h7F800000, 32'h0, 2'd2);
        idle_cycle();
        chk("arst_next_cls", {30'd0, wb_class}, 32'd2);
        chk("arst_next_dbl", {31'd0, wb_double}, 32'd0);
        idle_cycle();
        idle_cycle();

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
